// File: rtl/text_char_buffer_if.sv
`default_nettype none
// ============================================================================
// Module  : text_char_buffer_if
// Purpose : Byte-stream valid/ready handshake into the text character buffer.
// Signals :
//   in_valid  producer -> buffer  in_char holds a byte to consume
//   in_char   producer -> buffer  ASCII byte
//   in_ready  buffer -> producer  buffer accepts a byte this cycle
// Modports: master = byte producer (e.g. UART receiver), slave = buffer
// Revision: 1.0  initial release
// ============================================================================
interface text_char_buffer_if;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;

  modport master (output in_valid, output in_char, input in_ready);
  modport slave  (input in_valid, input in_char, output in_ready);
endinterface
`default_nettype wire

// File: rtl/text_char_buffer.sv
`default_nettype none
// ============================================================================
// Module  : text_char_buffer
// Purpose : Character screen memory feeding the text engine. Consumes a byte
//           stream, keeps a (2^ROW_BITS)x(2^COL_BITS) screen with a cursor,
//           handles CR, LF, BS, FF (clear) and hardware scroll-up.
// Ports   :
//   clk         system clock, all state changes on rising edge
//   reset       asynchronous active-high reset (starts a full-screen clear)
//   in_if       byte stream handshake (slave side)
//   rd_addr     cell address {row, col} from the text engine
//   rd_char     character stored at rd_addr (combinational read)
//   cursor_row  current cursor row
//   cursor_col  current cursor column
//   busy        a clear or scroll is in progress
// Revision: 1.0  initial release
// ============================================================================
module text_char_buffer #(
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  text_char_buffer_if.slave            in_if,
  input  logic [ROW_BITS+COL_BITS-1:0] rd_addr,
  output logic [7:0]                   rd_char,
  output logic [ROW_BITS-1:0]          cursor_row,
  output logic [COL_BITS-1:0]          cursor_col,
  output logic                         busy
);

  localparam int ADDR_BITS = ROW_BITS + COL_BITS;
  localparam int CELLS     = 1 << ADDR_BITS;

  localparam logic [7:0]           SPACE   = 8'h20;
  localparam logic [7:0]           CH_BS   = 8'h08;
  localparam logic [7:0]           CH_LF   = 8'h0A;
  localparam logic [7:0]           CH_FF   = 8'h0C;
  localparam logic [7:0]           CH_CR   = 8'h0D;

  localparam logic [ADDR_BITS-1:0] IDX_ONE    = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] IDX_LAST   = ADDR_BITS'(CELLS - 1);
  // One row's worth of cells: distance between a cell and the one below it.
  localparam logic [ADDR_BITS-1:0] COL_STRIDE = ADDR_BITS'(1 << COL_BITS);
  // Last destination of the copy phase; the bottom row is filled afterwards.
  localparam logic [ADDR_BITS-1:0] COPY_LAST  = ADDR_BITS'(CELLS - (1 << COL_BITS) - 1);
  localparam logic [ROW_BITS-1:0]  ROW_ONE    = ROW_BITS'(1);
  localparam logic [ROW_BITS-1:0]  ROW_LAST   = ROW_BITS'((1 << ROW_BITS) - 1);
  localparam logic [COL_BITS-1:0]  COL_ONE    = COL_BITS'(1);
  localparam logic [COL_BITS-1:0]  COL_LAST   = COL_BITS'((1 << COL_BITS) - 1);

  typedef enum logic [1:0] {
    ST_CLEAR     = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SCRL_COPY = 2'd2,
    ST_SCRL_FILL = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_BITS-1:0]  idx, idx_nxt;
  logic [ROW_BITS-1:0]   row, row_nxt;
  logic [COL_BITS-1:0]   col, col_nxt;

  logic                  we;
  logic [ADDR_BITS-1:0]  waddr;
  logic [7:0]            wdata;
  logic [7:0]            copy_src;
  logic                  printable;

  logic [7:0]            cells [CELLS];

  // ---------------------------------------------------------------------------
  // Cell array: single write port, two asynchronous read ports (display and
  // scroll source). Not reset; a reset always starts a clear pass instead.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (we) begin
      cells[waddr] <= wdata;
    end
  end

  assign rd_char   = cells[rd_addr];
  assign copy_src  = cells[idx + COL_STRIDE];
  assign printable = (in_if.in_char >= 8'h20) && (in_if.in_char <= 8'h7E);

  assign in_if.in_ready = (state == ST_IDLE);
  assign busy           = (state != ST_IDLE);
  assign cursor_row     = row;
  assign cursor_col     = col;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_CLEAR;
      idx   <= '0;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, cursor and write-port decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    row_nxt   = row;
    col_nxt   = col;
    we        = 1'b0;
    waddr     = idx;
    wdata     = SPACE;

    case (state)
      ST_CLEAR: begin
        we      = 1'b1;
        idx_nxt = idx + IDX_ONE;
        if (idx == IDX_LAST) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_SCRL_COPY: begin
        we      = 1'b1;
        wdata   = copy_src;
        idx_nxt = idx + IDX_ONE;
        if (idx == COPY_LAST) begin
          state_nxt = ST_SCRL_FILL;
        end
      end

      ST_SCRL_FILL: begin
        // idx continues from the copy phase straight into the bottom row.
        we      = 1'b1;
        idx_nxt = idx + IDX_ONE;
        if (idx == IDX_LAST) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (in_if.in_valid) begin
          if (printable) begin
            we    = 1'b1;
            waddr = {row, col};
            wdata = in_if.in_char;
            if (col == COL_LAST) begin
              col_nxt = '0;
              if (row == ROW_LAST) begin
                state_nxt = ST_SCRL_COPY;
                idx_nxt   = '0;
              end else begin
                row_nxt = row + ROW_ONE;
              end
            end else begin
              col_nxt = col + COL_ONE;
            end
          end else begin
            case (in_if.in_char)
              CH_CR: begin
                col_nxt = '0;
              end
              CH_LF: begin
                col_nxt = '0;
                if (row == ROW_LAST) begin
                  state_nxt = ST_SCRL_COPY;
                  idx_nxt   = '0;
                end else begin
                  row_nxt = row + ROW_ONE;
                end
              end
              CH_BS: begin
                // Step back one cell and blank it; the home cell is a hard stop.
                if (col != '0) begin
                  col_nxt = col - COL_ONE;
                  we      = 1'b1;
                  waddr   = {row, col - COL_ONE};
                end else if (row != '0) begin
                  row_nxt = row - ROW_ONE;
                  col_nxt = COL_LAST;
                  we      = 1'b1;
                  waddr   = {row - ROW_ONE, COL_LAST};
                end
              end
              CH_FF: begin
                state_nxt = ST_CLEAR;
                idx_nxt   = '0;
                row_nxt   = '0;
                col_nxt   = '0;
              end
              default: begin
                // Unrecognised control bytes are consumed without effect.
              end
            endcase
          end
        end
      end

      default: begin
        state_nxt = ST_CLEAR;
        idx_nxt   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_text_char_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_text_char_buffer
// Purpose : Self-checking bench for text_char_buffer. A screen model (rows x
//           columns array plus cursor) predicts cell contents, cursor and the
//           busy period that follows every clear or scroll.
// Revision: 1.0  initial release
// ============================================================================
module tb_text_char_buffer;

  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] rd_addr = '0;
  logic [7:0] rd_char;
  logic [1:0] cursor_row;
  logic [3:0] cursor_col;
  logic       busy;

  text_char_buffer_if bus ();

  text_char_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .in_if      (bus),
    .rd_addr    (rd_addr),
    .rd_char    (rd_char),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [7:0] scr [4][16];
  int         m_row;
  int         m_col;

  function automatic void model_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 16; c++) scr[r][c] = 8'h20;
    m_row = 0;
    m_col = 0;
  endfunction

  function automatic void model_scroll();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 16; c++) scr[r][c] = scr[r+1][c];
    for (int c = 0; c < 16; c++) scr[3][c] = 8'h20;
    m_row = 3;
    m_col = 0;
  endfunction

  // Applies one accepted byte; returns 1 when it starts a clear or scroll.
  function automatic bit model_apply(input logic [7:0] b);
    bit long_op = 1'b0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[m_row][m_col] = b;
      if (m_col == 15) begin
        if (m_row == 3) begin model_scroll(); long_op = 1'b1; end
        else begin m_row++; m_col = 0; end
      end else m_col++;
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      if (m_row == 3) begin model_scroll(); long_op = 1'b1; end
      else begin m_row++; m_col = 0; end
    end else if (b == 8'h08) begin
      if (m_col > 0) begin m_col--; scr[m_row][m_col] = 8'h20; end
      else if (m_row > 0) begin m_row--; m_col = 15; scr[m_row][m_col] = 8'h20; end
    end else if (b == 8'h0C) begin
      model_reset();
      long_op = 1'b1;
    end
    return long_op;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Presents a byte, returns how many edges passed before it was accepted.
  task automatic send_byte(input logic [7:0] b, output int waited);
    bus.in_valid = 1'b1;
    bus.in_char  = b;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < TIMEOUT) begin
      @(posedge clk); #1;
      waited++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
    checks++; if ({cursor_row, cursor_col} !== 6'd0) begin errors++; $display("FAIL reset_cursor: got %0d,%0d expected 0,0", cursor_row, cursor_col); end
    reset = 1'b0;
    model_reset();
    wait_idle(n);
    checks++; if (n !== 64) begin errors++; $display("FAIL reset_clear_cycles: got %0d expected 64", n); end
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a); #1;
      checks++; if (rd_char !== scr[a/16][a%16]) begin errors++; $display("FAIL reset_cell[%0d]: got %h expected %h", a, rd_char, scr[a/16][a%16]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hi();
    int w;
    logic [7:0] msg [2];
    msg[0] = 8'h48;
    msg[1] = 8'h49;
    for (int i = 0; i < 2; i++) begin
      send_byte(msg[i], w);
      void'(model_apply(msg[i]));
      checks++; if (w !== 0) begin errors++; $display("FAIL hi_accept_wait[%0d]: got %0d expected 0", i, w); end
    end
    rd_addr = 6'd0; #1;
    checks++; if (rd_char !== 8'h48) begin errors++; $display("FAIL hi_cell0: got %h expected 48", rd_char); end
    rd_addr = 6'd1; #1;
    checks++; if (rd_char !== 8'h49) begin errors++; $display("FAIL hi_cell1: got %h expected 49", rd_char); end
    checks++; if (cursor_row !== 2'd0 || cursor_col !== 4'd2) begin errors++; $display("FAIL hi_cursor: got %0d,%0d expected 0,2", cursor_row, cursor_col); end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_scroll();
    int w;
    int n;
    int late = 0;
    bit lo = 1'b0;
    send_byte(8'h0C, w);
    void'(model_apply(8'h0C));
    wait_idle(n);
    checks++; if (n !== 64) begin errors++; $display("FAIL ff_clear_cycles: got %0d expected 64", n); end
    for (int b = 8'h21; b <= 8'h60; b++) begin
      send_byte(8'(b), w);
      lo = model_apply(8'(b));
      if (w != 0) late++;
    end
    checks++; if (late !== 0) begin errors++; $display("FAIL fill_accept_waits: got %0d late bytes expected 0", late); end
    checks++; if (busy !== lo) begin errors++; $display("FAIL fill_busy_after_last: got %b expected %b", busy, lo); end
    wait_idle(n);
    checks++; if (n !== 64) begin errors++; $display("FAIL scroll_cycles: got %0d expected 64", n); end
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a); #1;
      checks++; if (rd_char !== scr[a/16][a%16]) begin errors++; $display("FAIL scroll_cell[%0d]: got %h expected %h", a, rd_char, scr[a/16][a%16]); end
    end
    rd_addr = 6'd0; #1;
    checks++; if (rd_char !== 8'h31) begin errors++; $display("FAIL scroll_row0_first: got %h expected 31", rd_char); end
    rd_addr = 6'd47; #1;
    checks++; if (rd_char !== 8'h60) begin errors++; $display("FAIL scroll_row2_last: got %h expected 60", rd_char); end
    checks++; if (cursor_row !== 2'd3 || cursor_col !== 4'd0) begin errors++; $display("FAIL scroll_cursor: got %0d,%0d expected 3,0", cursor_row, cursor_col); end
    @(posedge clk); #1;
  endtask

  task automatic test_backspace();
    int w;
    int n;
    send_byte(8'h0C, w);
    void'(model_apply(8'h0C));
    wait_idle(n);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h78, w);
      void'(model_apply(8'h78));
    end
    checks++; if (cursor_row !== 2'd1 || cursor_col !== 4'd0) begin errors++; $display("FAIL bs_setup_cursor: got %0d,%0d expected 1,0", cursor_row, cursor_col); end
    send_byte(8'h08, w);
    void'(model_apply(8'h08));
    checks++; if (cursor_row !== 2'd0 || cursor_col !== 4'd15) begin errors++; $display("FAIL bs_wrap_cursor: got %0d,%0d expected 0,15", cursor_row, cursor_col); end
    rd_addr = 6'd15; #1;
    checks++; if (rd_char !== 8'h20) begin errors++; $display("FAIL bs_cell15: got %h expected 20", rd_char); end
    send_byte(8'h0D, w);
    void'(model_apply(8'h0D));
    send_byte(8'h08, w);
    void'(model_apply(8'h08));
    checks++; if (cursor_row !== 2'd0 || cursor_col !== 4'd0) begin errors++; $display("FAIL bs_home_cursor: got %0d,%0d expected 0,0", cursor_row, cursor_col); end
    rd_addr = 6'd0; #1;
    checks++; if (rd_char !== 8'h78) begin errors++; $display("FAIL bs_home_cell0: got %h expected 78", rd_char); end
    @(posedge clk); #1;
  endtask

  task automatic test_clear_queued();
    int w;
    int n;
    send_byte(8'h0C, w);
    void'(model_apply(8'h0C));
    wait_idle(n);
    for (int i = 0; i < 37; i++) begin
      send_byte(8'h41, w);
      void'(model_apply(8'h41));
    end
    checks++; if (cursor_row !== 2'd2 || cursor_col !== 4'd5) begin errors++; $display("FAIL ffq_setup_cursor: got %0d,%0d expected 2,5", cursor_row, cursor_col); end
    // FF then 'B' back-to-back with in_valid never dropping between them.
    send_byte(8'h0C, w);
    void'(model_apply(8'h0C));
    send_byte(8'h42, w);
    void'(model_apply(8'h42));
    checks++; if (w !== 64) begin errors++; $display("FAIL ffq_hold_cycles: got %0d expected 64", w); end
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a); #1;
      checks++; if (rd_char !== scr[a/16][a%16]) begin errors++; $display("FAIL ffq_cell[%0d]: got %h expected %h", a, rd_char, scr[a/16][a%16]); end
    end
    checks++; if (cursor_row !== 2'd0 || cursor_col !== 4'd1) begin errors++; $display("FAIL ffq_cursor: got %0d,%0d expected 0,1", cursor_row, cursor_col); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_scroll();
    int w;
    int n;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h0A, w);
      void'(model_apply(8'h0A));
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rms_scroll_started: got %b expected 1", busy); end
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rms_ready: got %b expected 0", bus.in_ready); end
    checks++; if ({cursor_row, cursor_col} !== 6'd0) begin errors++; $display("FAIL rms_cursor_in_reset: got %0d,%0d expected 0,0", cursor_row, cursor_col); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    wait_idle(n);
    checks++; if (n !== 64) begin errors++; $display("FAIL rms_clear_cycles: got %0d expected 64", n); end
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a); #1;
      checks++; if (rd_char !== scr[a/16][a%16]) begin errors++; $display("FAIL rms_cell[%0d]: got %h expected %h", a, rd_char, scr[a/16][a%16]); end
    end
    checks++; if ({cursor_row, cursor_col} !== 6'd0) begin errors++; $display("FAIL rms_cursor: got %0d,%0d expected 0,0", cursor_row, cursor_col); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int w;
    int n;
    bit lo;
    logic [7:0] b;
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: b = 8'($urandom_range(32, 126));
        6: b = 8'h0D;
        7: b = 8'h0A;
        8: b = 8'h08;
        default: b = ($urandom_range(0, 3) == 0) ? 8'h0C : 8'($urandom_range(128, 255));
      endcase
      send_byte(b, w);
      lo = model_apply(b);
      checks++; if (w !== 0) begin errors++; $display("FAIL rnd_accept_wait[%0d]: got %0d expected 0", k, w); end
      wait_idle(n);
      checks++; if (n !== (lo ? 64 : 0)) begin errors++; $display("FAIL rnd_busy_cycles[%0d] byte %h: got %0d expected %0d", k, b, n, lo ? 64 : 0); end
      checks++; if (cursor_row !== 2'(m_row) || cursor_col !== 4'(m_col)) begin errors++; $display("FAIL rnd_cursor[%0d]: got %0d,%0d expected %0d,%0d", k, cursor_row, cursor_col, m_row, m_col); end
      if (k % 25 == 24) begin
        for (int a = 0; a < 64; a++) begin
          rd_addr = 6'(a); #1;
          checks++; if (rd_char !== scr[a/16][a%16]) begin errors++; $display("FAIL rnd_cell[%0d] step %0d: got %h expected %h", a, k, rd_char, scr[a/16][a%16]); end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    test_reset();
    test_hi();
    test_fill_scroll();
    test_backspace();
    test_clear_queued();
    test_reset_mid_scroll();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
